// File: rtl/issue_rr_scheduler_pkg.sv
// issue_rr_scheduler_pkg: shared defaults and types for the issue-queue scheduler
//   DEF_ENTRIES   queue slots (power of two, >= 4)
//   DEF_TAG_W     physical-register tag width
//   DEF_PAYLOAD_W opaque micro-op payload width
//   SLOT_W        slot index width for the default queue depth
//   entry_t       per-slot state at default widths
package issue_rr_scheduler_pkg;
    localparam int DEF_ENTRIES = 16;
    localparam int DEF_TAG_W = 6;
    localparam int DEF_PAYLOAD_W = 32;
    localparam int SLOT_W = $clog2(DEF_ENTRIES);
    typedef struct packed {
        logic valid;
        logic [DEF_TAG_W-1:0] tag_a;
        logic rdy_a;
        logic [DEF_TAG_W-1:0] tag_b;
        logic rdy_b;
        logic [DEF_PAYLOAD_W-1:0] payload;
    } entry_t;
endpackage

// File: rtl/issue_rr_scheduler_if.sv
// issue_rr_scheduler_if: dispatch, wakeup and issue signals of the issue queue
//   disp_*  : dispatch request (valid/ready, two source tags with ready flags, payload)
//   cdb_*   : wakeup broadcast (valid, tag)
//   issue_* : selected entry (valid/accept, payload, slot index)
//   count   : registered occupancy
//   master  : dispatch/CDB/FU side; slave: the scheduler
interface issue_rr_scheduler_if
    import issue_rr_scheduler_pkg::*;
#(
    parameter int ENTRIES = DEF_ENTRIES,
    parameter int TAG_W = DEF_TAG_W,
    parameter int PAYLOAD_W = DEF_PAYLOAD_W
);
    localparam int IW = $clog2(ENTRIES);
    logic disp_valid;
    logic disp_ready;
    logic [TAG_W-1:0] disp_tag_a;
    logic disp_rdy_a;
    logic [TAG_W-1:0] disp_tag_b;
    logic disp_rdy_b;
    logic [PAYLOAD_W-1:0] disp_payload;
    logic cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic issue_valid;
    logic issue_accept;
    logic [PAYLOAD_W-1:0] issue_payload;
    logic [IW-1:0] issue_slot;
    logic [IW:0] count;
    modport master (
        output disp_valid, disp_tag_a, disp_rdy_a, disp_tag_b, disp_rdy_b, disp_payload,
        output cdb_valid, cdb_tag, issue_accept,
        input disp_ready, issue_valid, issue_payload, issue_slot, count
    );
    modport slave (
        input disp_valid, disp_tag_a, disp_rdy_a, disp_tag_b, disp_rdy_b, disp_payload,
        input cdb_valid, cdb_tag, issue_accept,
        output disp_ready, issue_valid, issue_payload, issue_slot, count
    );
endinterface

// File: rtl/issue_rr_scheduler_rr_select.sv
// rr_select: combinational rotating-priority picker
//   req       : request vector
//   ptr       : highest-priority index this cycle
//   found     : any request present
//   grant_oh  : one-hot grant
//   grant_idx : index of the grant (first request at or after ptr, wrapping)
module rr_select
    import issue_rr_scheduler_pkg::*;
#(
    parameter int N = DEF_ENTRIES,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [N-1:0] grant_oh,
    output logic [W-1:0] grant_idx
);
    // Scan from the farthest offset back to ptr so the nearest request wins;
    // N is a power of two so the W-bit add wraps modulo N for free.
    always_comb begin
        found = |req;
        grant_idx = '0;
        grant_oh = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[ptr + W'(i)]) grant_idx = ptr + W'(i);
        end
        grant_oh[grant_idx] = found;
    end
endmodule

// File: rtl/issue_rr_scheduler.sv
// issue_rr_scheduler: issue queue with CDB wakeup and round-robin select
//   clk, rst : clock, synchronous active-high reset
//   stall    : freeze dispatch and issue; wakeup still captured
//   flush    : discard all entries
//   bus      : dispatch / wakeup / issue handshake (slave side)
module issue_rr_scheduler
    import issue_rr_scheduler_pkg::*;
#(
    parameter int ENTRIES = DEF_ENTRIES,
    parameter int TAG_W = DEF_TAG_W,
    parameter int PAYLOAD_W = DEF_PAYLOAD_W
) (
    input logic clk,
    input logic rst,
    input logic stall,
    input logic flush,
    issue_rr_scheduler_if.slave bus
);
    localparam int IW = $clog2(ENTRIES);
    localparam int CW = IW + 1;
    logic [ENTRIES-1:0] valid, rdy_a, rdy_b, cand, grant_oh;
    logic [TAG_W-1:0] tag_a [ENTRIES];
    logic [TAG_W-1:0] tag_b [ENTRIES];
    logic [PAYLOAD_W-1:0] payload [ENTRIES];
    logic [IW-1:0] ptr, sel, free_slot;
    logic [CW-1:0] count;
    logic found, disp_fire, issue_fire, byp_a, byp_b;
    assign cand = valid & rdy_a & rdy_b;
    assign bus.disp_ready = (count != CW'(ENTRIES)) & !stall & !flush;
    assign bus.issue_valid = found & !stall & !flush;
    assign bus.issue_payload = payload[sel];
    assign bus.issue_slot = sel;
    assign bus.count = count;
    assign disp_fire = bus.disp_valid & bus.disp_ready;
    assign issue_fire = bus.issue_valid & bus.issue_accept;
    // A source whose producer broadcasts in the dispatch cycle would otherwise miss its wakeup.
    assign byp_a = bus.cdb_valid && bus.disp_tag_a == bus.cdb_tag;
    assign byp_b = bus.cdb_valid && bus.disp_tag_b == bus.cdb_tag;
    rr_select #(.N(ENTRIES)) u_select (
        .req(cand),
        .ptr(ptr),
        .found(found),
        .grant_oh(grant_oh),
        .grant_idx(sel)
    );
    always_comb begin
        free_slot = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid[i]) free_slot = IW'(i);
        end
    end
    // Operand storage is not reset: valid gates every use of it.
    always_ff @(posedge clk) begin
        for (int i = 0; i < ENTRIES; i++) begin
            if (bus.cdb_valid && valid[i] && tag_a[i] == bus.cdb_tag) rdy_a[i] <= 1'b1;
            if (bus.cdb_valid && valid[i] && tag_b[i] == bus.cdb_tag) rdy_b[i] <= 1'b1;
        end
        if (disp_fire) begin
            tag_a[free_slot] <= bus.disp_tag_a;
            tag_b[free_slot] <= bus.disp_tag_b;
            rdy_a[free_slot] <= bus.disp_rdy_a | byp_a;
            rdy_b[free_slot] <= bus.disp_rdy_b | byp_b;
            payload[free_slot] <= bus.disp_payload;
        end
    end
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid <= '0;
            ptr <= '0;
            count <= '0;
        end else begin
            valid <= (valid & ~(issue_fire ? grant_oh : '0)) | (ENTRIES'(disp_fire) << free_slot);
            if (issue_fire) ptr <= sel + IW'(1);
            count <= count + CW'(disp_fire) - CW'(issue_fire);
        end
    end
endmodule

// File: tb/tb_issue_rr_scheduler.sv
// tb_issue_rr_scheduler: directed self-checking bench for issue_rr_scheduler
module tb_issue_rr_scheduler;
    import issue_rr_scheduler_pkg::*;
    localparam int CW = SLOT_W + 1;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic stall = 1'b0;
    logic flush = 1'b0;
    int errors = 0;
    int checks = 0;
    issue_rr_scheduler_if bus ();
    issue_rr_scheduler dut (.clk(clk), .rst(rst), .stall(stall), .flush(flush), .bus(bus));
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall = 1'b0;
        flush = 1'b0;
        bus.disp_valid = 1'b0;
        bus.disp_tag_a = '0;
        bus.disp_rdy_a = 1'b0;
        bus.disp_tag_b = '0;
        bus.disp_rdy_b = 1'b0;
        bus.disp_payload = '0;
        bus.cdb_valid = 1'b0;
        bus.cdb_tag = '0;
        bus.issue_accept = 1'b0;
    endtask

    task automatic set_disp(input logic [5:0] ta, input logic ra, input logic [5:0] tb_, input logic rb, input logic [31:0] p);
        bus.disp_valid = 1'b1;
        bus.disp_tag_a = ta;
        bus.disp_rdy_a = ra;
        bus.disp_tag_b = tb_;
        bus.disp_rdy_b = rb;
        bus.disp_payload = p;
    endtask

    task automatic flush_cycle();
        idle();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        checks++;
        if (bus.count !== CW'(0)) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.count); end
        checks++;
        if (bus.issue_valid !== 1'b0) begin errors++; $display("FAIL reset_issue_valid: got %b want 0", bus.issue_valid); end
        checks++;
        if (bus.disp_ready !== 1'b1) begin errors++; $display("FAIL reset_disp_ready: got %b want 1", bus.disp_ready); end
    endtask

    task automatic test_in_order();
        int exp_cnt [5] = '{1, 2, 2, 1, 0};
        for (int c = 0; c < 5; c++) begin
            if (c < 3) set_disp(0, 1, 0, 1, 32'(100 + c));
            else bus.disp_valid = 1'b0;
            bus.issue_accept = (c >= 2);
            #1;
            if (c >= 2) begin
                checks++;
                if (bus.issue_valid !== 1'b1 || bus.issue_slot !== SLOT_W'(c - 2) || bus.issue_payload !== 32'(98 + c)) begin
                    errors++;
                    $display("FAIL in_order_issue c=%0d: got v=%b slot=%0d pl=%0d want 1/%0d/%0d", c, bus.issue_valid, bus.issue_slot, bus.issue_payload, c - 2, 98 + c);
                end
            end
            cyc();
            checks++;
            if (bus.count !== CW'(exp_cnt[c])) begin errors++; $display("FAIL in_order_count c=%0d: got %0d want %0d", c, bus.count, exp_cnt[c]); end
        end
        idle();
    endtask

    task automatic test_full_wakeup();
        for (int i = 0; i < 16; i++) begin
            set_disp((i == 9) ? 6'd5 : 6'(20 + i), 0, (i == 9) ? 6'd5 : 6'(40 + i), 0, 32'(200 + i));
            cyc();
        end
        idle();
        #1;
        checks++;
        if (bus.count !== CW'(16)) begin errors++; $display("FAIL full_count: got %0d want 16", bus.count); end
        checks++;
        if (bus.disp_ready !== 1'b0) begin errors++; $display("FAIL full_disp_ready: got %b want 0", bus.disp_ready); end
        checks++;
        if (bus.issue_valid !== 1'b0) begin errors++; $display("FAIL full_none_ready: got %b want 0", bus.issue_valid); end
        bus.cdb_valid = 1'b1;
        bus.cdb_tag = 6'd5;
        cyc();
        bus.cdb_valid = 1'b0;
        bus.issue_accept = 1'b1;
        #1;
        checks++;
        if (bus.issue_valid !== 1'b1 || bus.issue_slot !== SLOT_W'(9) || bus.issue_payload !== 32'd209) begin
            errors++;
            $display("FAIL wakeup_slot9: got v=%b slot=%0d pl=%0d want 1/9/209", bus.issue_valid, bus.issue_slot, bus.issue_payload);
        end
        checks++;
        if (bus.disp_ready !== 1'b0) begin errors++; $display("FAIL full_issue_disp_ready: got %b want 0", bus.disp_ready); end
        cyc();
        bus.issue_accept = 1'b0;
        #1;
        checks++;
        if (bus.count !== CW'(15) || bus.issue_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_after_issue: got count=%0d v=%b want 15/0", bus.count, bus.issue_valid);
        end
        flush_cycle();
        #1;
        checks++;
        if (bus.count !== CW'(0)) begin errors++; $display("FAIL flush_count: got %0d want 0", bus.count); end
    endtask

    task automatic test_fairness();
        for (int i = 0; i < 16; i++) begin
            if (i == 0) set_disp(31, 0, 0, 1, 32'd300);
            else if (i >= 14) set_disp(0, 1, 0, 1, 32'(300 + i));
            else set_disp(30, 0, 30, 0, 32'(300 + i));
            cyc();
        end
        idle();
        #1;
        checks++;
        if (bus.issue_valid !== 1'b1 || bus.issue_slot !== SLOT_W'(14)) begin
            errors++;
            $display("FAIL fair_first: got v=%b slot=%0d want 1/14", bus.issue_valid, bus.issue_slot);
        end
        bus.issue_accept = 1'b1;
        bus.cdb_valid = 1'b1;
        bus.cdb_tag = 6'd31;
        cyc();
        bus.cdb_valid = 1'b0;
        #1;
        checks++;
        if (bus.issue_valid !== 1'b1 || bus.issue_slot !== SLOT_W'(15) || bus.issue_payload !== 32'd315) begin
            errors++;
            $display("FAIL fair_slot15: got v=%b slot=%0d pl=%0d want 1/15/315", bus.issue_valid, bus.issue_slot, bus.issue_payload);
        end
        cyc();
        #1;
        checks++;
        if (bus.issue_valid !== 1'b1 || bus.issue_slot !== SLOT_W'(0) || bus.issue_payload !== 32'd300) begin
            errors++;
            $display("FAIL fair_wrap_slot0: got v=%b slot=%0d pl=%0d want 1/0/300", bus.issue_valid, bus.issue_slot, bus.issue_payload);
        end
        cyc();
        bus.issue_accept = 1'b0;
        #1;
        checks++;
        if (bus.count !== CW'(13) || bus.issue_valid !== 1'b0) begin
            errors++;
            $display("FAIL fair_after: got count=%0d v=%b want 13/0", bus.count, bus.issue_valid);
        end
        flush_cycle();
    endtask

    task automatic test_bypass();
        set_disp(7, 0, 0, 1, 32'h77);
        bus.cdb_valid = 1'b1;
        bus.cdb_tag = 6'd7;
        #1;
        checks++;
        if (bus.issue_valid !== 1'b0) begin errors++; $display("FAIL bypass_same_cycle: got %b want 0", bus.issue_valid); end
        cyc();
        set_disp(8, 0, 0, 1, 32'h88);
        #1;
        checks++;
        if (bus.issue_valid !== 1'b1 || bus.issue_slot !== SLOT_W'(0) || bus.issue_payload !== 32'h77) begin
            errors++;
            $display("FAIL bypass_issue: got v=%b slot=%0d pl=%h want 1/0/77", bus.issue_valid, bus.issue_slot, bus.issue_payload);
        end
        bus.issue_accept = 1'b1;
        cyc();
        idle();
        #1;
        checks++;
        if (bus.issue_valid !== 1'b0 || bus.count !== CW'(1)) begin
            errors++;
            $display("FAIL bypass_no_match: got v=%b count=%0d want 0/1", bus.issue_valid, bus.count);
        end
        flush_cycle();
    endtask

    task automatic test_hold_stall();
        logic [31:0] exp_pl [3] = '{32'hA0, 32'hB0, 32'hC0};
        set_disp(0, 1, 0, 1, 32'hA0);
        cyc();
        set_disp(0, 1, 0, 1, 32'hB0);
        cyc();
        set_disp(12, 0, 0, 1, 32'hC0);
        cyc();
        idle();
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (bus.issue_valid !== 1'b1 || bus.issue_slot !== SLOT_W'(0) || bus.issue_payload !== 32'hA0) begin
                errors++;
                $display("FAIL hold_k%0d: got v=%b slot=%0d pl=%h want 1/0/a0", k, bus.issue_valid, bus.issue_slot, bus.issue_payload);
            end
            cyc();
            checks++;
            if (bus.count !== CW'(3)) begin errors++; $display("FAIL hold_count_k%0d: got %0d want 3", k, bus.count); end
        end
        stall = 1'b1;
        bus.cdb_valid = 1'b1;
        bus.cdb_tag = 6'd12;
        bus.issue_accept = 1'b1;
        set_disp(0, 1, 0, 1, 32'hDD);
        #1;
        checks++;
        if (bus.issue_valid !== 1'b0 || bus.disp_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_outputs: got iv=%b dr=%b want 0/0", bus.issue_valid, bus.disp_ready);
        end
        cyc();
        checks++;
        if (bus.count !== CW'(3)) begin errors++; $display("FAIL stall_count: got %0d want 3", bus.count); end
        idle();
        bus.issue_accept = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (bus.issue_valid !== 1'b1 || bus.issue_slot !== SLOT_W'(k) || bus.issue_payload !== exp_pl[k]) begin
                errors++;
                $display("FAIL post_stall_k%0d: got v=%b slot=%0d pl=%h want 1/%0d/%h", k, bus.issue_valid, bus.issue_slot, bus.issue_payload, k, exp_pl[k]);
            end
            cyc();
        end
        checks++;
        if (bus.count !== CW'(0)) begin errors++; $display("FAIL post_stall_count: got %0d want 0", bus.count); end
        idle();
    endtask

    task automatic test_flush();
        for (int i = 0; i < 10; i++) begin
            set_disp(0, 1, 0, 1, 32'(400 + i));
            cyc();
        end
        idle();
        #1;
        checks++;
        if (bus.count !== CW'(10) || bus.issue_valid !== 1'b1 || bus.issue_slot !== SLOT_W'(3)) begin
            errors++;
            $display("FAIL pre_flush: got count=%0d v=%b slot=%0d want 10/1/3", bus.count, bus.issue_valid, bus.issue_slot);
        end
        flush = 1'b1;
        bus.issue_accept = 1'b1;
        set_disp(0, 1, 0, 1, 32'd999);
        #1;
        checks++;
        if (bus.issue_valid !== 1'b0 || bus.disp_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_outputs: got iv=%b dr=%b want 0/0", bus.issue_valid, bus.disp_ready);
        end
        cyc();
        idle();
        #1;
        checks++;
        if (bus.count !== CW'(0) || bus.issue_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_after: got count=%0d v=%b want 0/0", bus.count, bus.issue_valid);
        end
        set_disp(0, 1, 0, 1, 32'h55);
        cyc();
        idle();
        #1;
        checks++;
        if (bus.issue_valid !== 1'b1 || bus.issue_slot !== SLOT_W'(0) || bus.issue_payload !== 32'h55 || bus.count !== CW'(1)) begin
            errors++;
            $display("FAIL flush_redispatch: got v=%b slot=%0d pl=%h count=%0d want 1/0/55/1", bus.issue_valid, bus.issue_slot, bus.issue_payload, bus.count);
        end
    endtask

    task automatic test_reset_mid_fill();
        for (int i = 0; i < 5; i++) begin
            set_disp(50, 0, 50, 0, 32'(500 + i));
            cyc();
        end
        #1;
        checks++;
        if (bus.count !== CW'(6)) begin errors++; $display("FAIL mid_fill_count: got %0d want 6", bus.count); end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        idle();
        #1;
        checks++;
        if (bus.count !== CW'(0) || bus.issue_valid !== 1'b0 || bus.disp_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_fill: got count=%0d iv=%b dr=%b want 0/0/1", bus.count, bus.issue_valid, bus.disp_ready);
        end
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_full_wakeup();
        test_fairness();
        test_bypass();
        test_hold_stall();
        test_flush();
        test_reset_mid_fill();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
